// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm
//   Scan controller for a 4x4 matrix keypad. It drives one active-low row at a
//   time and debounces a single key press on the synchronized active-low
//   column inputs. Each press registers exactly one key. The two most recent
//   keys are kept for a dual-digit display.
//
//   Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue the held key
//   every REPEAT_CYCLES cycles. Without it, hold time has no effect and no
//   repeat logic is built.
//
// Ports
//   clk        in   1  slow system clock
//   reset      in   1  synchronous, active-high
//   cols       in   4  synchronized columns, active-low (4'b1111 = nothing pressed)
//   rows       out  4  row drive, active-low, at most one row low
//   key_valid  out  1  one-cycle pulse when a key is accepted
//   key_code   out  4  hex code of the held / last accepted key
//   new_value  out  4  most recent accepted key
//   old_value  out  4  previous accepted key
module keypad_scan_fsm #(
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 48,
    parameter int REPEAT_CYCLES   = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] new_value,
    output logic [3:0] old_value
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // One counter width covers every count so the counters share a type.
    localparam int MAX_PARAM = (SETTLE_CYCLES > DEBOUNCE_CYCLES)
                             ? ((SETTLE_CYCLES > REPEAT_CYCLES) ? SETTLE_CYCLES : REPEAT_CYCLES)
                             : ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES);
    localparam int CNT_W = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [1:0]       row_reg, row_next;
    logic [1:0]       col_reg, col_next;
    logic [CNT_W-1:0] settle_reg, settle_next;
    logic [CNT_W-1:0] deb_reg, deb_next;
    logic [3:0]       cap_reg, cap_next;
    logic [3:0]       code_reg, code_next;
    logic [3:0]       new_reg, new_next;
    logic [3:0]       old_reg, old_next;
    logic             valid_reg, valid_next;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_reg, rep_next;
`endif

    logic       single_low;
    logic [1:0] col_enc;

    // Keypad legend, indexed by {row, col}.
    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Only a pattern with exactly one low column is a valid single press.
    always_comb begin
        single_low = 1'b1;
        col_enc    = 2'd0;
        case (cols)
            4'b1110: col_enc = 2'd0;
            4'b1101: col_enc = 2'd1;
            4'b1011: col_enc = 2'd2;
            4'b0111: col_enc = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        settle_next = settle_reg;
        deb_next    = deb_reg;
        cap_next    = cap_reg;
        code_next   = code_reg;
        new_next    = new_reg;
        old_next    = old_reg;
        valid_next  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next    = '0;
`endif
        case (state_reg)
            ST_SCAN: begin
                if (settle_reg >= SETTLE_LAST) begin
                    settle_next = '0;
                    if (single_low) begin
                        // The row stays driven so the captured key can be debounced.
                        cap_next   = cols;
                        col_next   = col_enc;
                        code_next  = key_lut(row_reg, col_enc);
                        deb_next   = CNT_ONE;
                        state_next = ST_DEBOUNCE;
                    end else begin
                        row_next = row_reg + 2'd1;
                    end
                end else begin
                    settle_next = settle_reg + CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (cols == cap_reg) begin
                    if (deb_reg >= DEB_LAST) begin
                        state_next = ST_HELD;
                        valid_next = 1'b1;
                        old_next   = new_reg;
                        new_next   = code_reg;
                    end else begin
                        deb_next = deb_reg + CNT_ONE;
                    end
                end else begin
                    // A bounce drops the candidate and moves on to the next row.
                    state_next  = ST_SCAN;
                    row_next    = row_reg + 2'd1;
                    settle_next = '0;
                end
            end
            ST_HELD: begin
                if (cols == 4'hF) begin
                    state_next = ST_RELEASE;
                    deb_next   = CNT_ONE;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_reg >= REP_LAST) begin
                        rep_next = '0;
                        // The guard keeps key_valid from being high two cycles in a row.
                        if (!valid_reg) begin
                            valid_next = 1'b1;
                            old_next   = new_reg;
                            new_next   = code_reg;
                        end
                    end else begin
                        rep_next = rep_reg + CNT_ONE;
                    end
`endif
                end
            end
            default: begin
                if (cols == 4'hF) begin
                    if (deb_reg >= DEB_LAST) begin
                        state_next  = ST_SCAN;
                        row_next    = 2'd0;
                        settle_next = '0;
                    end else begin
                        deb_next = deb_reg + CNT_ONE;
                    end
                end else begin
                    // A bounce during release returns to HELD and never re-registers.
                    state_next = ST_HELD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_SCAN;
            row_reg    <= 2'd0;
            col_reg    <= 2'd0;
            settle_reg <= '0;
            deb_reg    <= '0;
            cap_reg    <= 4'hF;
            code_reg   <= 4'h0;
            new_reg    <= 4'h0;
            old_reg    <= 4'h0;
            valid_reg  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            settle_reg <= settle_next;
            deb_reg    <= deb_next;
            cap_reg    <= cap_next;
            code_reg   <= code_next;
            new_reg    <= new_next;
            old_reg    <= old_next;
            valid_reg  <= valid_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_reg    <= rep_next;
`endif
        end
    end

    // Row drive: the selected row is low and all other rows are high.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rows
            assign rows[gi] = (row_reg != 2'(gi));
        end
    endgenerate

    assign key_valid = valid_reg;
    assign key_code  = code_reg;
    assign new_value = new_reg;
    assign old_value = old_reg;

endmodule

// File: tb/tb_keypad_scan_fsm.sv
module tb_keypad_scan_fsm;
    localparam int SETTLE = 3;
    localparam int DEB    = 4;
    localparam int REP    = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HOLD_AFTER = 5;
`else
    localparam int HOLD_AFTER = 100;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] new_value;
    logic [3:0] old_value;

    // Pressed keys, indexed row*4+col.
    logic [15:0] key_mask = '0;

    int n_assert = 0;
    int n_fail = 0;
    int pulse_count = 0;
    logic prev_valid = 1'b0;
    logic [3:0] exp_new = 4'h0;
    logic [3:0] exp_old = 4'h0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    keypad_scan_fsm #(
        .SETTLE_CYCLES(SETTLE),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cols(cols),
        .rows(rows),
        .key_valid(key_valid),
        .key_code(key_code),
        .new_value(new_value),
        .old_value(old_value)
    );

    // Physical matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [7:0] e;
        if (key_valid === 1'b1) begin
            pulse_count++;
            check("no_back_to_back", {15'b0, prev_valid}, 16'h0);
            check("pulse_expected", 16'(exp_q.size() > 0), 16'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_new_old", {8'h0, new_value, old_value}, {8'h0, e});
                check("pulse_key_code", {12'h0, key_code}, {12'h0, e[7:4]});
                $display("pulse: new=%h old=%h code=%h", new_value, old_value, key_code);
            end
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_key(input logic [3:0] k);
        exp_old = exp_new;
        exp_new = k;
        exp_q.push_back({exp_new, exp_old});
    endtask

    task automatic do_reset();
        key_mask = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_new = 4'h0;
        exp_old = 4'h0;
        exp_q.delete();
    endtask

    task automatic wait_pulse(input string tag, input int max_cycles);
        int start;
        int i;
        start = pulse_count;
        i = 0;
        while (pulse_count == start && i < max_cycles) begin
            tick(1);
            i++;
        end
        check(tag, 16'(pulse_count - start), 16'd1);
    endtask

    initial begin
        int base;
        int guard;
        logic [3:0] seen;

        // 1: reset values and first row advance
        reset = 1'b1;
        tick(2);
        check("rst_rows", {12'h0, rows}, 16'h000E);
        check("rst_valid", {15'h0, key_valid}, 16'h0);
        check("rst_new_old", {8'h0, new_value, old_value}, 16'h0);
        check("rst_code", {12'h0, key_code}, 16'h0);
        reset = 1'b0;
        tick(2);
        check("row0_held", {12'h0, rows}, 16'h000E);
        tick(1);
        check("row1_after3", {12'h0, rows}, 16'h000D);

        // 2: steady key 6 gives exactly one pulse
        do_reset();
        base = pulse_count;
        key_mask[6] = 1'b1;
        expect_key(4'h6);
        wait_pulse("t2_accept", 4*SETTLE + DEB + 6);
        check("t2_new_old", {8'h0, new_value, old_value}, 16'h0060);
        check("t2_code", {12'h0, key_code}, 16'h6);
        tick(HOLD_AFTER);
        check("t2_one_pulse", 16'(pulse_count - base), 16'd1);
        key_mask = '0;
        tick(12);

        // 3: 6, release, A
        do_reset();
        base = pulse_count;
        key_mask[6] = 1'b1;
        expect_key(4'h6);
        wait_pulse("t3_accept6", 4*SETTLE + DEB + 6);
        key_mask = '0;
        tick(12);
        key_mask[3] = 1'b1;
        expect_key(4'hA);
        wait_pulse("t3_acceptA", 4*SETTLE + DEB + 6);
        check("t3_new_old", {8'h0, new_value, old_value}, 16'h00A6);
        key_mask = '0;
        tick(12);
        check("t3_two_pulses", 16'(pulse_count - base), 16'd2);

        // 4: bouncing key 9 is rejected, steady 9 is accepted
        base = pulse_count;
        for (int i = 0; i < 20; i++) begin
            key_mask[10] = 1'b1;
            tick(2);
            key_mask[10] = 1'b0;
            tick(1);
        end
        check("t4_bounce_no_pulse", 16'(pulse_count - base), 16'd0);
        key_mask[10] = 1'b1;
        expect_key(4'h9);
        wait_pulse("t4_accept9", 4*SETTLE + DEB + 6);
        check("t4_new_old", {8'h0, new_value, old_value}, 16'h009A);
        key_mask = '0;
        tick(12);

        // 5: two keys on one row are ignored and scanning continues
        base = pulse_count;
        key_mask[0] = 1'b1;
        key_mask[1] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            seen = seen | ~rows;
        end
        check("t5_rows_cycle", {12'h0, seen}, 16'h000F);
        check("t5_no_pulse", 16'(pulse_count - base), 16'd0);
        key_mask = '0;
        tick(4);

`ifdef KEYPAD_AUTOREPEAT_EN
        // 6: autorepeat while holding key 0
        do_reset();
        key_mask[13] = 1'b1;
        for (int i = 0; i < 4; i++) expect_key(4'h0);
        wait_pulse("t6_accept0", 4*SETTLE + DEB + 6);
        base = pulse_count;
        tick(35);
        check("t6_repeats", 16'(pulse_count - base), 16'd3);
        check("t6_new_old", {8'h0, new_value, old_value}, 16'h0000);
        key_mask = '0;
        tick(12);
`endif

        // Reset in the middle of DEBOUNCE: no pulse, outputs back to reset values.
        key_mask[9] = 1'b1;
        expect_key(4'h8);
        wait_pulse("rd_accept8", 4*SETTLE + DEB + 6);
        key_mask = '0;
        tick(12);
        guard = 0;
        while (rows !== 4'b0111 && guard < 20) begin
            tick(1);
            guard++;
        end
        check("rd_sync_row3", {12'h0, rows}, 16'h0007);
        guard = 0;
        while (rows !== 4'b1110 && guard < 20) begin
            tick(1);
            guard++;
        end
        check("rd_sync_row0", {12'h0, rows}, 16'h000E);
        key_mask[0] = 1'b1;
        tick(4);
        check("rd_pre_reset_new", {12'h0, new_value}, 16'h0008);
        base = pulse_count;
        reset = 1'b1;
        tick(2);
        key_mask = '0;
        check("rd_rows", {12'h0, rows}, 16'h000E);
        check("rd_new_old", {8'h0, new_value, old_value}, 16'h0000);
        check("rd_code", {12'h0, key_code}, 16'h0);
        reset = 1'b0;
        tick(6);
        check("rd_no_pulse", 16'(pulse_count - base), 16'd0);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
